// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the IF/MEM memory bus arbiter: FSM encodings, stall vectors, grant helper.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_IF_BUSY = 2'd1;
    localparam logic [1:0] ST_DM_BUSY = 2'd2;
    localparam logic [1:0] ST_IF_DROP = 2'd3;

    localparam int STALL_W      = 6;
    localparam int STALL_BIT_PC = 0;
    localparam int STALL_BIT_IF = 1;
    localparam int STALL_BIT_ID = 2;
    localparam int STALL_BIT_EX = 3;
    localparam int STALL_BIT_MEM = 4;

    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    localparam logic [STALL_W-1:0] STALL_IF   = STALL_W'((1 << STALL_BIT_PC) | (1 << STALL_BIT_IF));
    localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(STALL_IF | (1 << STALL_BIT_ID) |
                                                         (1 << STALL_BIT_EX) | (1 << STALL_BIT_MEM));

    localparam logic [3:0] SEL_WORD = 4'b1111;
    localparam logic       GRANT_IF = 1'b0;
    localparam logic       GRANT_DM = 1'b1;

    // Data wins unless fetch is also eligible and data was the last port served.
    function automatic logic pick_dm(input logic if_ok, input logic dm_ok, input logic last_grant);
        return dm_ok && (!if_ok || (last_grant == GRANT_IF));
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Core-side fetch/data ports, memory-side bus and stall/error status of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: n/a (wiring only).
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [3:0]        dm_sel_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;

    logic              bus_req_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;

    logic [5:0]        stall_o;
    logic              bus_err_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_rdata_o, if_ack_o,
        input  dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
        output dm_rdata_o, dm_ack_o,
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i,
        output stall_o, bus_err_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_rdata_o, if_ack_o,
        output dm_req_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
        input  dm_rdata_o, dm_ack_o,
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i,
        input  stall_o, bus_err_o
    );
endinterface

// File: rtl/bus_arbiter_tmo_cnt.sv
// Bus-cycle timeout counter: cleared on grant, counts while busy, saturates at LIMIT-1.
// Latency: expired is a registered-count compare, high in the LIMIT-th busy cycle.
// Backpressure: none; en simply freezes the count.
module arb_tmo_cnt #(
    parameter int LIMIT = 15,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LAST);
endmodule

// File: rtl/bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data ports, drives pipeline stalls.
// Latency: bus_req_o one cycle after a granted request; port ack one cycle after bus_ack_i or timeout.
// Backpressure: requesters hold req until ack; stall_o freezes the pipeline while a port waits.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 15
) (
    input logic          clk,
    input logic          rst,
    bus_arbiter_if.slave bif
);
    typedef struct packed {
        logic              we;
        logic [3:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    logic [1:0]        state_q;
    logic              last_grant_q;
    bus_cmd_t          cmd_q;
    logic              bus_req_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic              bus_err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic if_ok, dm_ok, grant_dm, grant_if, busy, tmo_expired, done;

    // A port whose ack is pulsing still shows its old request; it must not be re-served.
    assign if_ok    = bif.if_req_i && !bif.if_flush_i && !if_ack_q;
    assign dm_ok    = bif.dm_req_i && !dm_ack_q;
    assign grant_dm = (state_q == ST_IDLE) && pick_dm(if_ok, dm_ok, last_grant_q);
    assign grant_if = (state_q == ST_IDLE) && if_ok && !pick_dm(if_ok, dm_ok, last_grant_q);
    assign busy     = (state_q != ST_IDLE);
    assign done     = busy && (bif.bus_ack_i || tmo_expired);

    arb_tmo_cnt #(.LIMIT(TMO_CYC), .W(8)) u_tmo_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant_dm || grant_if),
        .en      (busy),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_IF;
            cmd_q        <= '0;
            bus_req_q    <= 1'b0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            bus_err_q    <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            if (done) begin
                bus_req_q <= 1'b0;
                cmd_q     <= '0;
                state_q   <= ST_IDLE;
                if (!bif.bus_ack_i) begin
                    bus_err_q <= 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_dm) begin
                        state_q      <= ST_DM_BUSY;
                        last_grant_q <= GRANT_DM;
                        bus_req_q    <= 1'b1;
                        cmd_q        <= '{we: bif.dm_we_i, sel: bif.dm_sel_i,
                                          addr: bif.dm_addr_i, wdata: bif.dm_wdata_i};
                    end else if (grant_if) begin
                        state_q      <= ST_IF_BUSY;
                        last_grant_q <= GRANT_IF;
                        bus_req_q    <= 1'b1;
                        cmd_q        <= '{we: 1'b0, sel: SEL_WORD,
                                          addr: bif.if_addr_i, wdata: '0};
                    end
                end
                ST_IF_BUSY: begin
                    // A flush in the completing cycle discards the fetched word as well.
                    if (done && !bif.if_flush_i) begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= bif.bus_ack_i ? bif.bus_rdata_i : '0;
                    end else if (!done && bif.if_flush_i) begin
                        state_q <= ST_IF_DROP;
                    end
                end
                ST_DM_BUSY: begin
                    if (done) begin
                        dm_ack_q   <= 1'b1;
                        dm_rdata_q <= (bif.bus_ack_i && !cmd_q.we) ? bif.bus_rdata_i : '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bif.bus_req_o   = bus_req_q;
    assign bif.bus_we_o    = cmd_q.we;
    assign bif.bus_sel_o   = cmd_q.sel;
    assign bif.bus_addr_o  = cmd_q.addr;
    assign bif.bus_wdata_o = cmd_q.wdata;
    assign bif.if_ack_o    = if_ack_q;
    assign bif.if_rdata_o  = if_rdata_q;
    assign bif.dm_ack_o    = dm_ack_q;
    assign bif.dm_rdata_o  = dm_rdata_q;
    assign bif.bus_err_o   = bus_err_q;

    always_comb begin
        bif.stall_o = STALL_NONE;
        if (bif.dm_req_i && !dm_ack_q) begin
            bif.stall_o = STALL_MEM;
        end else if (bif.if_req_i && !if_ack_q && !bif.if_flush_i) begin
            bif.stall_o = STALL_IF;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: fetch, write, arbitration, flush, timeout, reset, early req drop.
// Inputs change 2ns after the rising edge; outputs are sampled in the same window.
module tb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n;

    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(15)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bif.if_req_i    = 1'b0;
        bif.if_addr_i   = '0;
        bif.if_flush_i  = 1'b0;
        bif.dm_req_i    = 1'b0;
        bif.dm_we_i     = 1'b0;
        bif.dm_sel_i    = 4'h0;
        bif.dm_addr_i   = '0;
        bif.dm_wdata_i  = '0;
        bif.bus_rdata_i = '0;
        bif.bus_ack_i   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
        nxt();
    endtask

    task automatic dm_set(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bif.dm_req_i   = 1'b1;
        bif.dm_we_i    = we;
        bif.dm_sel_i   = sel;
        bif.dm_addr_i  = addr;
        bif.dm_wdata_i = wdata;
    endtask

    // Called in the first cycle bus_req_o is high; returns in the cycle after the bus ack edge.
    task automatic ack_after(input string tag, input int waits, input logic [31:0] d);
        for (int i = 0; i < waits; i++) begin
            nxt();
            check({tag, "_hold_req"}, bif.bus_req_o, 1'b1);
            check({tag, "_no_ack"}, {bif.if_ack_o, bif.dm_ack_o}, 2'b00);
        end
        bif.bus_ack_i   = 1'b1;
        bif.bus_rdata_i = d;
        nxt();
        bif.bus_ack_i   = 1'b0;
        bif.bus_rdata_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        nxt();
        nxt();
        check("rst_bus_req", bif.bus_req_o, 1'b0);
        check("rst_bus_cmd", {bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o}, 64'h0);
        check("rst_acks", {bif.if_ack_o, bif.dm_ack_o}, 2'b00);
        check("rst_rdata", {bif.if_rdata_o, bif.dm_rdata_o}, 64'h0);
        check("rst_err", bif.bus_err_o, 1'b0);
        check("rst_stall", bif.stall_o, 6'b000000);
        rst = 1'b1;
        nxt();

        // Fetch only, 3 wait states.
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h0000_0004;
        #1;
        check("f_stall_wait", bif.stall_o, 6'b000011);
        nxt();
        check("f_bus_req", bif.bus_req_o, 1'b1);
        check("f_bus_addr", bif.bus_addr_o, 32'h4);
        check("f_bus_sel_we", {bif.bus_sel_o, bif.bus_we_o}, 5'b11110);
        check("f_stall_busy", bif.stall_o, 6'b000011);
        ack_after("f", 3, 32'h3401_0100);
        check("f_if_ack", bif.if_ack_o, 1'b1);
        check("f_if_rdata", bif.if_rdata_o, 32'h3401_0100);
        check("f_req_drop", bif.bus_req_o, 1'b0);
        check("f_stall_done", bif.stall_o, 6'b000000);
        bif.if_req_i = 1'b0;
        nxt();
        check("f_ack_single", bif.if_ack_o, 1'b0);
        check("f_rdata_hold", bif.if_rdata_o, 32'h3401_0100);

        // Data write, zero wait states.
        dm_set(1'b1, 4'b0011, 32'h10, 32'hDEAD_BEEF);
        #1;
        check("w_stall_wait", bif.stall_o, 6'b011111);
        nxt();
        check("w_bus_req", bif.bus_req_o, 1'b1);
        check("w_bus_cmd", {bif.bus_we_o, bif.bus_sel_o}, 5'b10011);
        check("w_bus_addr", bif.bus_addr_o, 32'h10);
        check("w_bus_wdata", bif.bus_wdata_o, 32'hDEAD_BEEF);
        check("w_stall_busy", bif.stall_o, 6'b011111);
        ack_after("w", 0, 32'hFFFF_FFFF);
        check("w_dm_ack", bif.dm_ack_o, 1'b1);
        check("w_dm_rdata_zero", bif.dm_rdata_o, 32'h0);
        check("w_req_drop", bif.bus_req_o, 1'b0);
        idle_inputs();
        nxt();
        check("w_ack_single", bif.dm_ack_o, 1'b0);

        // Arbitration: data wins the first conflict after reset, then alternation.
        do_reset();
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h100;
        dm_set(1'b0, 4'hF, 32'h200, 32'h0);
        nxt();
        check("a1_dm_first", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h200});
        ack_after("a1", 0, 32'hAAAA_5555);
        check("a1_dm_ack", bif.dm_ack_o, 1'b1);
        check("a1_dm_rdata", bif.dm_rdata_o, 32'hAAAA_5555);
        check("a1_idle_gap", bif.bus_req_o, 1'b0);
        bif.dm_req_i = 1'b0;
        nxt();
        check("a2_if_next", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h100});
        dm_set(1'b0, 4'hF, 32'h300, 32'h0);
        ack_after("a2", 1, 32'h1111_1111);
        check("a2_if_ack", {bif.if_ack_o, bif.if_rdata_o}, {1'b1, 32'h1111_1111});
        bif.if_req_i = 1'b0;
        nxt();
        check("a3_dm_pending", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h300});
        ack_after("a3", 0, 32'h2222_2222);
        check("a3_dm_ack", {bif.dm_ack_o, bif.dm_rdata_o}, {1'b1, 32'h2222_2222});
        bif.dm_req_i = 1'b0;
        nxt();
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h104;
        dm_set(1'b0, 4'hF, 32'h304, 32'h0);
        nxt();
        check("a4_conflict_if", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h104});
        ack_after("a4", 0, 32'h3333_3333);
        check("a4_if_ack", {bif.if_ack_o, bif.if_rdata_o}, {1'b1, 32'h3333_3333});
        bif.if_req_i = 1'b0;
        nxt();
        check("a5_dm_after", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h304});
        ack_after("a5", 0, 32'h4444_4444);
        check("a5_dm_ack", {bif.dm_ack_o, bif.dm_rdata_o}, {1'b1, 32'h4444_4444});
        bif.dm_req_i = 1'b0;
        nxt();

        // Flush one cycle into a fetch: bus cycle finishes, no if_ack, then the new fetch runs.
        bif.if_req_i  = 1'b1;
        bif.if_addr_i = 32'h40;
        nxt();
        check("fl_bus_req", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h40});
        bif.if_flush_i = 1'b1;
        #1;
        check("fl_stall_flush", bif.stall_o, 6'b000000);
        nxt();
        bif.if_flush_i = 1'b0;
        bif.if_addr_i  = 32'h80;
        check("fl_req_held", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h40});
        ack_after("fl", 1, 32'hBAD0_BAD0);
        check("fl_no_if_ack", bif.if_ack_o, 1'b0);
        check("fl_req_drop", bif.bus_req_o, 1'b0);
        check("fl_rdata_kept", bif.if_rdata_o, 32'h3333_3333);
        nxt();
        check("fl_refetch", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h80});
        ack_after("fl2", 0, 32'h5555_5555);
        check("fl2_if_ack", {bif.if_ack_o, bif.if_rdata_o}, {1'b1, 32'h5555_5555});
        bif.if_req_i = 1'b0;
        nxt();

        // Data read with no bus ack: forced completion after 15 bus cycles.
        dm_set(1'b0, 4'hF, 32'h500, 32'h0);
        nxt();
        check("to_bus_req", bif.bus_req_o, 1'b1);
        check("to_err_before", bif.bus_err_o, 1'b0);
        n = 0;
        while (bif.bus_req_o && n < 40) begin
            n++;
            nxt();
        end
        check("to_req_cycles", n, 15);
        check("to_dm_ack", bif.dm_ack_o, 1'b1);
        check("to_dm_rdata", bif.dm_rdata_o, 32'h0);
        check("to_err_set", bif.bus_err_o, 1'b1);
        bif.dm_req_i = 1'b0;
        nxt();
        bif.bus_ack_i   = 1'b1;
        bif.bus_rdata_i = 32'h7777_7777;
        nxt();
        bif.bus_ack_i   = 1'b0;
        bif.bus_rdata_i = '0;
        check("to_late_ack_ign", {bif.if_ack_o, bif.dm_ack_o, bif.bus_req_o}, 3'b000);
        nxt();
        check("to_err_sticky", bif.bus_err_o, 1'b1);
        check("to_rdata_hold", bif.dm_rdata_o, 32'h0);

        // Reset mid DM_BUSY after 2 wait states.
        dm_set(1'b0, 4'hF, 32'h600, 32'h0);
        nxt();
        nxt();
        nxt();
        check("rm_busy", bif.bus_req_o, 1'b1);
        rst = 1'b0;
        bif.dm_req_i = 1'b0;
        #1;
        check("rm_bus_req", bif.bus_req_o, 1'b0);
        check("rm_bus_addr", bif.bus_addr_o, 32'h0);
        check("rm_err_clr", bif.bus_err_o, 1'b0);
        check("rm_stall", bif.stall_o, 6'b000000);
        nxt();
        nxt();
        rst = 1'b1;
        nxt();
        nxt();
        check("rm_no_ack", {bif.if_ack_o, bif.dm_ack_o, bif.bus_req_o}, 3'b000);
        dm_set(1'b1, 4'hF, 32'h700, 32'h1234_5678);
        nxt();
        check("rm_next_req", {bif.bus_req_o, bif.bus_addr_o}, {1'b1, 32'h700});
        check("rm_next_wdata", bif.bus_wdata_o, 32'h1234_5678);
        ack_after("rm", 2, 32'h0);
        check("rm_next_ack", bif.dm_ack_o, 1'b1);
        bif.dm_req_i = 1'b0;
        nxt();

        // Requester drops dm_req before ack: transfer still completes and acks.
        dm_set(1'b0, 4'hF, 32'h800, 32'h0);
        nxt();
        check("pv_bus_req", bif.bus_req_o, 1'b1);
        bif.dm_req_i = 1'b0;
        $display("note: protocol violation injected, dm_req released before dm_ack");
        ack_after("pv", 1, 32'h6666_6666);
        check("pv_dm_ack", {bif.dm_ack_o, bif.dm_rdata_o}, {1'b1, 32'h6666_6666});
        nxt();
        check("pv_quiet", {bif.dm_ack_o, bif.bus_req_o}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
